// File: rtl/counter_nch.sv
// Multi-channel timer/counter on the MIO_BUS register port.
// Each channel has a prescaler, a reload register, four counting modes, an output bit and a maskable interrupt.
module counter_nch #(
  parameter int unsigned CH = 3,
  parameter int unsigned W  = 32,
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          we,
  input  logic [5:0]    addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CH-1:0] ch_out,
  output logic          irq
);

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_FREERUN  = 2'b11
  } mode_e;

  logic [W-1:0]  load_q  [CH];
  logic [W-1:0]  load_d  [CH];
  logic [W-1:0]  count_q [CH];
  logic [W-1:0]  count_d [CH];
  logic [PW-1:0] presc_q [CH];
  logic [PW-1:0] presc_d [CH];
  logic [PW-1:0] pre_q   [CH];
  logic [PW-1:0] pre_d   [CH];
  logic [3:0]    ctrl_q  [CH];
  logic [3:0]    ctrl_d  [CH];
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] out_q, out_d;
  logic [CH-1:0] pulse_q, pulse_d;

  logic [3:0]    sel;
  logic [1:0]    rsel;
  logic [CH-1:0] wr_ch, wr0, tick, term, ien;
  mode_e         mode [CH];

  assign sel  = addr[5:2];
  assign rsel = addr[1:0];

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      wr_ch[i] = we && (sel == 4'(i));
      wr0[i]   = wr_ch[i] && (rsel == 2'd0);
      tick[i]  = ctrl_q[i][0] && (pre_q[i] == presc_q[i]);
      ien[i]   = ctrl_q[i][3];
      mode[i]  = mode_e'(ctrl_q[i][2:1]);
    end
  end

  // pulse_q marks an output that is a one-clock pulse, so it drops on the next edge whatever the mode is by then
  always_comb begin
    pend_d  = pend_q;
    out_d   = out_q & ~pulse_q;
    pulse_d = '0;
    term    = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      load_d[i]  = load_q[i];
      count_d[i] = count_q[i];
      presc_d[i] = presc_q[i];
      pre_d[i]   = pre_q[i];
      ctrl_d[i]  = ctrl_q[i];

      if (wr_ch[i] && (rsel == 2'd3) && wdata[0]) begin
        pend_d[i] = 1'b0;
      end

      if (ctrl_q[i][0]) begin
        pre_d[i] = tick[i] ? '0 : pre_q[i] + 1'b1;
      end

      if (tick[i] && !wr0[i]) begin
        if (mode[i] == MODE_FREERUN) begin
          count_d[i] = count_q[i] + 1'b1;
          term[i]    = (count_q[i] == '1);
        end else if (count_q[i] > W'(1)) begin
          count_d[i] = count_q[i] - 1'b1;
        end else if (count_q[i] == W'(1)) begin
          term[i] = 1'b1;
        end
      end

      if (term[i]) begin
        pend_d[i] = 1'b1;
        case (mode[i])
          MODE_ONESHOT: begin
            count_d[i]   = '0;
            ctrl_d[i][0] = 1'b0;
            out_d[i]     = 1'b1;
          end
          MODE_PERIODIC: begin
            count_d[i] = load_q[i];
            out_d[i]   = 1'b1;
            pulse_d[i] = 1'b1;
          end
          MODE_SQUARE: begin
            count_d[i] = load_q[i];
            out_d[i]   = ~out_d[i];
          end
          default: begin
            out_d[i]   = 1'b1;
            pulse_d[i] = 1'b1;
          end
        endcase
      end

      if (wr_ch[i]) begin
        case (rsel)
          2'd0: begin
            load_d[i]  = wdata;
            count_d[i] = wdata;
            pre_d[i]   = '0;
            out_d[i]   = 1'b0;
            pulse_d[i] = 1'b0;
          end
          2'd1:    ctrl_d[i]  = wdata[3:0];
          2'd2:    presc_d[i] = PW'(wdata);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned i = 0; i < CH; i++) begin
        load_q[i]  <= '0;
        count_q[i] <= '0;
        presc_q[i] <= '0;
        pre_q[i]   <= '0;
        ctrl_q[i]  <= '0;
      end
      pend_q  <= '0;
      out_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        load_q[i]  <= load_d[i];
        count_q[i] <= count_d[i];
        presc_q[i] <= presc_d[i];
        pre_q[i]   <= pre_d[i];
        ctrl_q[i]  <= ctrl_d[i];
      end
      pend_q  <= pend_d;
      out_q   <= out_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (sel == 4'(i)) begin
        case (rsel)
          2'd0:    rdata = count_q[i];
          2'd1:    rdata = W'(ctrl_q[i]);
          2'd2:    rdata = W'(presc_q[i]);
          default: rdata = W'({pend_q[i], out_q[i]});
        endcase
      end
    end
  end

  assign ch_out = out_q;
  assign irq    = |(pend_q & ien);

endmodule

// File: tb/tb_counter_nch.sv
// Bench for counter_nch: a cycle model checked every negedge, plus directed scenarios with literal expectations.
module tb_counter_nch;
  localparam int unsigned CH   = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned PW   = 8;
  localparam int unsigned MAXC = 1 << W;

  logic          clk   = 1'b0;
  logic          RSTN  = 1'b0;
  logic          we    = 1'b0;
  logic [5:0]    addr  = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic [CH-1:0] ch_out;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  counter_nch #(.CH(CH), .W(W), .PW(PW)) dut (
    .clk(clk), .RSTN(RSTN), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ch_out(ch_out), .irq(irq)
  );

  // Model: counts kept as plain integers, wraps done modulo 2^W
  int unsigned m_load [CH];
  int unsigned m_cnt  [CH];
  int unsigned m_ps   [CH];
  int unsigned m_pre  [CH];
  bit [3:0]    m_ctrl [CH];
  bit          m_pend [CH];
  bit          m_out  [CH];
  bit          m_pulse[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_load[c] = 0; m_cnt[c] = 0; m_ps[c] = 0; m_pre[c] = 0;
      m_ctrl[c] = '0; m_pend[c] = 0; m_out[c] = 0; m_pulse[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit mine, fire, term;
      int unsigned md;
      mine = we && (int'(addr[5:2]) == c);
      if (m_pulse[c]) begin
        m_out[c] = 0;
        m_pulse[c] = 0;
      end
      fire = m_ctrl[c][0] && (m_pre[c] == m_ps[c]);
      if (m_ctrl[c][0]) m_pre[c] = fire ? 0 : m_pre[c] + 1;
      if (mine && addr[1:0] == 2'd3 && wdata[0]) m_pend[c] = 0;
      term = 0;
      if (fire && !(mine && addr[1:0] == 2'd0)) begin
        md = m_ctrl[c][2:1];
        if (md == 3) begin
          m_cnt[c] = (m_cnt[c] + 1) % MAXC;
          term = (m_cnt[c] == 0);
        end else if (m_cnt[c] > 1) begin
          m_cnt[c] = m_cnt[c] - 1;
        end else if (m_cnt[c] == 1) begin
          term = 1;
        end
        if (term) begin
          m_pend[c] = 1;
          case (md)
            0: begin m_cnt[c] = 0; m_ctrl[c][0] = 0; m_out[c] = 1; end
            1: begin m_cnt[c] = m_load[c]; m_out[c] = 1; m_pulse[c] = 1; end
            2: begin m_cnt[c] = m_load[c]; m_out[c] = !m_out[c]; end
            default: begin m_out[c] = 1; m_pulse[c] = 1; end
          endcase
        end
      end
      if (mine) begin
        case (addr[1:0])
          2'd0: begin
            m_load[c] = wdata; m_cnt[c] = wdata; m_pre[c] = 0;
            m_out[c] = 0; m_pulse[c] = 0;
          end
          2'd1: m_ctrl[c] = wdata[3:0];
          2'd2: m_ps[c] = wdata;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [5:0] a);
    int unsigned c;
    c = a[5:2];
    if (c >= CH) return '0;
    case (a[1:0])
      2'd0:    return W'(m_cnt[c]);
      2'd1:    return W'(m_ctrl[c]);
      2'd2:    return W'(m_ps[c]);
      default: return W'({m_pend[c], m_out[c]});
    endcase
  endfunction

  always @(posedge clk or negedge RSTN) begin
    if (!RSTN) model_reset();
    else       model_edge();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CH-1:0] eo;
      logic          ei;
      ei = 1'b0;
      for (int c = 0; c < CH; c++) begin
        eo[c] = m_out[c];
        ei = ei | (m_pend[c] & m_ctrl[c][3]);
      end
      check("model_ch_out", 32'(ch_out), 32'(eo));
      check("model_irq", 32'(irq), 32'(ei));
      check("model_rdata", 32'(rdata), 32'(m_read(addr)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int c, input int r, input int d);
    we    = 1'b1;
    addr  = {c[3:0], r[1:0]};
    wdata = d[W-1:0];
    step();
    we    = 1'b0;
  endtask

  task automatic rd(input int c, input int r, output logic [W-1:0] v);
    addr = {c[3:0], r[1:0]};
    #1;
    v = rdata;
  endtask

  initial begin
    logic [W-1:0] v;
    int os_exp [10];
    os_exp = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
    chk_en = 1'b1;

    // reset state
    repeat (2) step();
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(c, r, v);
        check("reset_rdata", 32'(v), 0);
        step();
      end
    end
    check("reset_ch_out", 32'(ch_out), 0);
    check("reset_irq", 32'(irq), 0);
    RSTN = 1'b1;
    step();

    // periodic: ch0, P=0, N=4, irq_en
    wr(0, 2, 0);
    wr(0, 1, 4'b1011);
    wr(0, 0, 4);
    for (int j = 1; j <= 12; j++) begin
      if (j == 6) begin
        we = 1'b1; addr = {4'd0, 2'd3}; wdata = 1;
      end
      step();
      we = 1'b0;
      check("per_out", 32'(ch_out[0]), (j % 4 == 0) ? 1 : 0);
      check("per_irq", 32'(irq), ((j >= 4 && j < 6) || j >= 8) ? 1 : 0);
    end
    wr(0, 1, 0);
    wr(0, 3, 1);

    // prescaled one-shot: ch1, P=2, N=3
    wr(1, 2, 2);
    wr(1, 1, 4'b0001);
    wr(1, 0, 3);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      rd(1, 0, v);
      check("os_count", 32'(v), os_exp[j]);
      check("os_out", 32'(ch_out[1]), (j == 9) ? 1 : 0);
    end
    rd(1, 1, v);
    check("os_ctrl", 32'(v), 0);
    repeat (6) step();
    rd(1, 3, v);
    check("os_status", 32'(v), 3);
    rd(1, 0, v);
    check("os_idle", 32'(v), 0);
    wr(1, 3, 1);

    // square: ch3, P=1, N=2
    wr(3, 2, 1);
    wr(3, 1, 4'b0101);
    wr(3, 0, 2);
    for (int j = 1; j <= 16; j++) begin
      step();
      check("sq_out", 32'(ch_out[3]), ((j / 4) % 2 == 1) ? 1 : 0);
    end
    wr(3, 1, 0);
    wr(3, 3, 1);

    // out-of-range channel index
    wr(5, 0, 8'h55);
    wr(5, 1, 8'h0F);
    wr(5, 2, 3);
    for (int r = 0; r < 4; r++) begin
      rd(5, r, v);
      check("oob_rd5", 32'(v), 0);
      step();
    end
    rd(4, 0, v);
    check("oob_rd4", 32'(v), 0);
    step();

    // free-run wrap: ch2, W=8, load 0xFE
    wr(2, 2, 0);
    wr(2, 1, 4'b0111);
    wr(2, 0, 8'hFE);
    rd(2, 0, v);
    check("fr_fe", 32'(v), 32'hFE);
    step();
    rd(2, 0, v);
    check("fr_ff", 32'(v), 32'hFF);
    step();
    rd(2, 0, v);
    check("fr_wrap", 32'(v), 0);
    rd(2, 3, v);
    check("fr_status", 32'(v), 3);
    step();
    check("fr_pulse_end", 32'(ch_out[2]), 0);
    rd(2, 0, v);
    check("fr_after", 32'(v), 1);
    wr(2, 1, 0);
    wr(2, 3, 1);

    // reg0 write on a tick edge: ch1, P=2, periodic
    wr(1, 2, 2);
    wr(1, 1, 4'b0011);
    wr(1, 0, 5);
    step();
    step();
    wr(1, 0, 7);
    rd(1, 0, v);
    check("col_wr_cnt", 32'(v), 7);
    step();
    step();
    rd(1, 0, v);
    check("col_pre_hold", 32'(v), 7);
    step();
    rd(1, 0, v);
    check("col_pre_tick", 32'(v), 6);
    wr(1, 1, 0);

    // pending clear on the terminal-event edge: ch0, P=0, N=2
    wr(0, 2, 0);
    wr(0, 1, 4'b1011);
    wr(0, 0, 2);
    step();
    we = 1'b1; addr = {4'd0, 2'd3}; wdata = 1;
    step();
    we = 1'b0;
    rd(0, 3, v);
    check("col_pend", 32'(v), 3);
    check("col_irq", 32'(irq), 1);

    // asynchronous reset mid-count
    step();
    check("rst_pre_irq", 32'(irq), 1);
    RSTN = 1'b0;
    #1;
    check("rst_async_irq", 32'(irq), 0);
    check("rst_async_out", 32'(ch_out), 0);
    rd(0, 0, v);
    check("rst_async_cnt", 32'(v), 0);
    step();
    RSTN = 1'b1;
    step();
    rd(0, 1, v);
    check("rst_ctrl", 32'(v), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_nch.md
# counter_nch

Parametrised multi-channel timer/counter for the MIO_BUS peripheral space and the next-generation replacement for the fixed three-channel counter. It has CH independent channels. Each channel has its own programmable prescaler, a reload register and four counting modes. Each channel drives an output bit and raises a maskable interrupt request. The CPU programs and reads the block through a single-cycle register port clocked by the I/O clock.

## Interface
Parameters:
- CH, 3: number of channels, 1..16
- W, 32: counter and reload width
- PW, 16: prescaler width

Ports:
- clk  in  1  I/O clock; all state updates on the rising edge
- RSTN  in  1  asynchronous, active-low reset
- we  in  1  register write strobe, sampled on the rising edge of clk
- addr  in  6  addr[5:2] selects the channel, addr[1:0] selects the register (0 load/count, 1 control, 2 prescale, 3 status)
- wdata  in  W  write data
- rdata  out  W  combinational read of the addressed register
- ch_out  out  CH  per-channel output bit
- irq  out  1  OR over channels of (pending & irq_en)

## Operation
- Reset: load, count, prescale, pre_cnt, ctrl, pending, ch_out and irq all clear to 0. Every channel is disabled after reset.
- Control register, per channel:
  - bit0 enable
  - bits[2:1] mode: 00 one-shot, 01 periodic, 10 square, 11 free-run
  - bit3 irq_en
- Reads:
  - reg0 returns the live count.
  - reg1 returns ctrl, zero-extended.
  - reg2 returns prescale.
  - reg3 returns {pending, ch_out} in bits [1:0].
  - A channel index ≥ CH reads 0 and ignores writes.
- Write to reg0: load=count=wdata, pre_cnt=0, ch_out=0.
- Write to reg1 or reg2: updates only that register. Count and pre_cnt are not altered.
- Write to reg3 with wdata[0]=1: clears pending.
- Tick: while enabled, pre_cnt counts 0..prescale. The tick fires on the cycle pre_cnt==prescale, and pre_cnt returns to 0. Prescale 0 gives a tick every clk. While disabled, pre_cnt holds.
- Down modes (00/01/10), on a tick:
  - count>1: decrement.
  - count==1: terminal event.
  - count==0: no action (idle).
- Terminal event per mode:
  - one-shot: count becomes 0, enable clears, ch_out becomes 1 and holds until the next reg0 write.
  - periodic: count reloads from load, ch_out pulses high for exactly one clk.
  - square: count reloads from load, ch_out toggles.
- Free-run (11): count increments on each tick. On a tick at count = 2^W−1 it wraps to 0, which is a terminal event. ch_out pulses for one clk.
- Every terminal event sets pending.
- Priority:
  - A same-cycle terminal event and reg3 clear leave pending=1 (set wins).
  - A same-cycle reg0 write and tick: the write wins and the tick is discarded.
- Changing mode mid-count takes effect on the next tick. Count is not reset.
- RSTN low mid-operation: all state clears immediately, irq falls asynchronously.

## Timing
- Writes take effect at the sampling edge and are visible on rdata in the following cycle.
- With the channel enabled, prescale P, and a reg0 write of N (N≥1) at edge k:
  - The first tick is at edge k+P+1.
  - The terminal event is at edge k+N·(P+1).
  - Periodic: subsequent terminal events every N·(P+1) clks.
  - Square: the period is 2·N·(P+1) clks.
- ch_out, pending and irq are registered. All three change on the terminal-event edge, with no extra latency.
- An irq_en change alters irq in the same cycle (combinational mask of the registered pending).
- rdata has zero latency (combinational from addr and registers).
- Each channel accepts one write per clk.

## Test plan
- Reset: hold RSTN=0, then release. Required: rdata=0 for every reg/channel, ch_out=0, irq=0. Pulling RSTN low mid-count clears immediately.
- Periodic: ch0, P=0, N=4, ctrl=0b1011 (irq_en, periodic, enable). Required: ch_out[0] one-clk pulses at edges k+4, k+8, k+12. irq rises at k+4. A reg3 clear at k+6 drops irq, and it rises again at k+8.
- Prescaled one-shot: ch1, P=2, N=3, mode 00, enabled. Required: count reads 3,3,3,2,2,2,1,1,1,0. ch_out[1]=1 from edge k+9. ctrl enable reads 0 afterwards. No further events.
- Square with CH=4: ch3, P=1, N=2. Required: ch_out[3] toggles every 4 clks (period 8). Index 5 reads 0 and writes to it have no effect.
- Free-run wrap with W=8: load 0xFE, mode 11, P=0. Required: count 0xFE, 0xFF, 0x00. Pending set at the wrap edge.
- Collisions: clear and terminal event on the same edge leave pending=1. A reg0 write and a tick on the same edge load the written value, with pre_cnt=0.
